// File: rtl/mdu.sv
// Multi-cycle multiply/divide unit with HI/LO registers.
// Result is computed at accept and committed after the busy window expires.
module mdu #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam int CMAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW   = $clog2(CMAX + 1);

    typedef enum logic {IDLE, RUN} state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [63:0]   pend_q, pend_d;
    logic          wr_q, wr_d;
    logic [31:0]   hi_q, hi_d;
    logic [31:0]   lo_q, lo_d;

    logic signed [63:0] smul;
    logic        [63:0] umul;
    logic        [31:0] b_nz;
    logic        [31:0] b_sdiv;
    logic signed [31:0] sq, sr;
    logic        [31:0] uq, ur;
    logic               ovf;

    assign smul = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
    assign umul = {32'b0, A} * {32'b0, B};

    // A zero divisor or the 0x80000000/-1 case divides by 1 instead:
    // zero is never committed, and A/1 is exactly the overflow answer.
    assign ovf    = (A == 32'h8000_0000) && (B == 32'hFFFF_FFFF);
    assign b_nz   = (B == 32'b0) ? 32'd1 : B;
    assign b_sdiv = ovf ? 32'd1 : b_nz;
    assign sq     = $signed(A) / $signed(b_sdiv);
    assign sr     = $signed(A) % $signed(b_sdiv);
    assign uq     = A / b_nz;
    assign ur     = A % b_nz;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pend_d  = pend_q;
        wr_d    = wr_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    unique case (op)
                        3'd1: begin
                            pend_d  = smul;
                            wr_d    = 1'b1;
                            cnt_d   = CW'(MULT_CYCLES);
                            state_d = RUN;
                        end
                        3'd2: begin
                            pend_d  = umul;
                            wr_d    = 1'b1;
                            cnt_d   = CW'(MULT_CYCLES);
                            state_d = RUN;
                        end
                        3'd3: begin
                            pend_d  = {sr, sq};
                            wr_d    = (B != 32'b0);
                            cnt_d   = CW'(DIV_CYCLES);
                            state_d = RUN;
                        end
                        3'd4: begin
                            pend_d  = {ur, uq};
                            wr_d    = (B != 32'b0);
                            cnt_d   = CW'(DIV_CYCLES);
                            state_d = RUN;
                        end
                        3'd5: hi_d = A;
                        3'd6: lo_d = A;
                        default: ;
                    endcase
                end
            end
            RUN: begin
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = IDLE;
                    if (wr_q) begin
                        hi_d = pend_q[63:32];
                        lo_d = pend_q[31:0];
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            pend_q  <= '0;
            wr_q    <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
            wr_q    <= wr_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign busy = (state_q == RUN);
    assign HI   = hi_q;
    assign LO   = lo_q;

endmodule

// File: tb/tb_mdu.sv
// Scoreboard bench for mdu: expected HI/LO and busy length queued at issue,
// checked when busy falls.
module tb_mdu;

    logic        clk;
    logic        rst;
    logic        start;
    logic [2:0]  op;
    logic [31:0] A, B;
    logic        busy;
    logic [31:0] HI, LO;

    mdu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk  (clk),
        .rst  (rst),
        .start(start),
        .op   (op),
        .A    (A),
        .B    (B),
        .busy (busy),
        .HI   (HI),
        .LO   (LO)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [63:0] hilo;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    logic bsy_prev = 1'b0;
    int   bsy_cnt  = 0;

    always @(negedge clk) begin
        if (!rst) begin
            bsy_prev = 1'b0;
            bsy_cnt  = 0;
        end else begin
            if (busy) bsy_cnt++;
            if (bsy_prev && !busy) begin
                if (sb.size() == 0) begin
                    chk("unexpected_commit", 64'd1, 64'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk({e.tag, "_hilo"}, {HI, LO}, e.hilo);
                    chk({e.tag, "_busy"}, 64'(bsy_cnt), 64'(e.cyc));
                end
                bsy_cnt = 0;
            end
            bsy_prev = busy;
        end
    end

    task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        start = 1'b1;
        op    = o;
        A     = a;
        B     = b;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic push(input string t, input logic [63:0] hl, input int c);
        exp_t e;
        e.tag  = t;
        e.hilo = hl;
        e.cyc  = c;
        sb.push_back(e);
    endtask

    // Returns on the first negedge with busy low.
    task automatic wait_idle(input string t);
        int k;
        k = 0;
        while (busy && k < 50) begin
            @(negedge clk);
            k++;
        end
        if (busy) chk({t, "_timeout"}, 64'd1, 64'd0);
    endtask

    initial begin
        logic [31:0] ra, rb;
        rst   = 1'b0;
        start = 1'b0;
        op    = 3'd0;
        A     = '0;
        B     = '0;
        repeat (2) @(negedge clk);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_hilo", {HI, LO}, 64'd0);
        rst = 1'b1;

        push("mult", {32'hFFFF_FFFF, 32'hFFFF_FFFE}, 5);
        issue(3'd1, 32'hFFFF_FFFF, 32'h2);
        issue(3'd6, 32'hABCD_1234, 32'h0);
        wait_idle("mult");
        start = 1'b1;
        op    = 3'd6;
        A     = 32'hABCD_1234;
        @(negedge clk);
        start = 1'b0;
        chk("mtlo_after", {HI, LO}, {32'hFFFF_FFFF, 32'hABCD_1234});
        chk("mtlo_nobusy", 64'(busy), 64'd0);

        push("multu", {32'h1, 32'hFFFF_FFFE}, 5);
        issue(3'd2, 32'hFFFF_FFFF, 32'h2);
        wait_idle("multu");

        push("div", {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 10);
        issue(3'd3, 32'hFFFF_FFF9, 32'h2);
        wait_idle("div");

        push("divu", {32'h1, 32'h3}, 10);
        issue(3'd4, 32'h7, 32'h2);
        wait_idle("divu");

        issue(3'd5, 32'h11, 32'h0);
        issue(3'd6, 32'h22, 32'h0);
        chk("mthi_mtlo", {HI, LO}, {32'h11, 32'h22});
        push("divu0", {32'h11, 32'h22}, 10);
        issue(3'd4, 32'h7, 32'h0);
        wait_idle("divu0");

        push("divovf", {32'h0, 32'h8000_0000}, 10);
        issue(3'd3, 32'h8000_0000, 32'hFFFF_FFFF);
        A = 32'h1234_5678;
        B = 32'h3;
        wait_idle("divovf");

        // MTHI held through the commit edge must be ignored
        push("commit_edge", {32'h2, 32'he}, 10);
        issue(3'd4, 32'd100, 32'd7);
        start = 1'b1;
        op    = 3'd5;
        A     = 32'hDEAD_BEEF;
        wait_idle("commit_edge");
        start = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 4; i++) begin
            ra = $urandom;
            rb = $urandom;
            push("rnd_multu", {32'b0, ra} * {32'b0, rb}, 5);
            issue(3'd2, ra, rb);
            wait_idle("rnd_multu");
            rb = rb >> $urandom_range(0, 28);
            if (rb == 0) rb = 32'd3;
            push("rnd_divu", {ra % rb, ra / rb}, 10);
            issue(3'd4, ra, rb);
            wait_idle("rnd_divu");
        end

        issue(3'd3, 32'd50, 32'd3);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("arst_busy", 64'(busy), 64'd0);
        chk("arst_hilo", {HI, LO}, 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (15) @(negedge clk);
        chk("post_rst_busy", 64'(busy), 64'd0);
        chk("post_rst_hilo", {HI, LO}, 64'd0);
        chk("sb_empty", 64'(sb.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mdu.md
Name: mdu

Overview:
Multi-cycle multiply/divide unit with HI/LO registers for the MIPS datapath.
- Consumes the two GRF read ports (RD1 → A, RD2 → B) in the execute stage.
- Asserts busy so control can stall any later MDU-using instruction.
- HI/LO feed the writeback mux for MFHI/MFLO.

Parameters:
- MULT_CYCLES, 5, busy cycles for MULT/MULTU (≥1).
- DIV_CYCLES, 10, busy cycles for DIV/DIVU (≥1).

Ports:
- clk  input  1  system clock; all state updates on posedge.
- rst  input  1  asynchronous, active-low reset (0 = reset).
- start  input  1  request strobe; sampled at posedge.
- op  input  3  0 NOP, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 reserved (treated as NOP).
- A  input  32  operand 1 (GRF RD1); rs / dividend / MTHI-MTLO data.
- B  input  32  operand 2 (GRF RD2); rt / divisor.
- busy  output  1  computation in flight.
- HI  output  32  HI register.
- LO  output  32  LO register.

Behaviour:
- Reset
  - rst=0 immediately (asynchronously) clears HI=0, LO=0, busy=0, cycle counter=0 and pending result.
  - Any in-flight operation is abandoned; no commit occurs after reset releases.
- States: IDLE, RUN.
- IDLE
  - A request is accepted at a posedge only when start=1 and busy=0.
  - op 1-4: latch the computed 64-bit result into an internal pending register at that edge.
    - Load counter with MULT_CYCLES or DIV_CYCLES.
    - busy=1 from that edge; go to RUN.
  - op 5 (MTHI): HI<=A at that edge; busy stays 0.
  - op 6 (MTLO): LO<=A at that edge; busy stays 0.
  - op 0 or 7: no effect.
- RUN
  - Counter decrements each posedge.
  - On the edge where it reaches zero: commit pending result to HI/LO, busy<=0, go to IDLE.
  - busy is therefore high for exactly N cycles; HI/LO keep their old values until the commit edge.
- Requests while busy=1 are ignored, including MTHI/MTLO; control guarantees stall.
  - A request asserted on the commit edge is also ignored, since busy is still 1 at that edge.
- A request is accepted the cycle after busy falls. There is no back-to-back overlap.
- Arithmetic
  - MULT: signed 32x32 → 64; HI = [63:32], LO = [31:0].
  - MULTU: unsigned 32x32 → 64.
  - DIV: signed; LO = quotient truncated toward zero; HI = remainder with sign of dividend.
  - DIVU: unsigned; LO = quotient, HI = remainder.
- Divide-by-zero (B=0, DIV/DIVU)
  - Request still occupies DIV_CYCLES with busy=1.
  - HI/LO left unchanged at commit.
- Signed overflow: DIV 0x80000000 / 0xFFFFFFFF → LO=0x80000000, HI=0x00000000.
- Operands are captured at the accept edge; A/B changes during RUN have no effect.
- HI/LO outputs are direct register outputs; no combinational path from inputs.

Test Plan:
- Reset: hold rst=0 mid-RUN of a DIV → busy=0, HI=LO=0 asynchronously. After release, no commit ever appears; HI/LO stay 0.
- MULT A=0xFFFFFFFF, B=0x00000002 → busy high exactly 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFE. MULTU with the same operands → HI=0x00000001, LO=0xFFFFFFFE.
- DIV A=0xFFFFFFF9 (-7), B=2 → busy 10 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU A=7, B=2 → LO=3, HI=1.
- DIVU A=7, B=0 with HI=0x11, LO=0x22 preloaded via MTHI/MTLO → busy 10 cycles; HI=0x11, LO=0x22 unchanged.
- MTLO A=0xABCD1234 issued while busy (during MULT) → ignored; final LO = product. Same MTLO issued in the cycle after busy falls → LO=0xABCD1234 next edge, busy never rises.
- DIV 0x80000000 / 0xFFFFFFFF → LO=0x80000000, HI=0. Change A/B during RUN → result unaffected.
